// File: rtl/axi_mem_slave_pkg.sv
// Shared constants, FSM encoding and helpers for the AXI4 memory subordinate.
package axi_mem_slave_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_DATA  = 3'd1,
      ST_WR_RESP  = 3'd2,
      ST_RD_FETCH = 3'd3,
      ST_RD_DATA  = 3'd4
   } state_t;

   // Number of byte lanes in one data beat.
   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read data only updates when the port is enabled, so it holds across stalls.
module axi_mem_slave_ram
   import axi_mem_slave_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic                          clk,
   input  logic                          i_en,
   input  logic [byte_lanes(DATA_W)-1:0] i_we,
   input  logic [ADDR_W-1:0]             i_addr,
   input  logic [DATA_W-1:0]             i_wdata,
   output logic [DATA_W-1:0]             o_rdata
);

   localparam int LANES = byte_lanes(DATA_W);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Byte-lane write plus registered read; read returns the pre-write contents.
   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int b = 0; b < LANES; b++) begin
            if (i_we[b]) begin
               r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
         o_rdata <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 subordinate memory: one INCR burst at a time, byte-enabled writes,
// zero-bubble reads via prefetch. Upper address bits alias onto the RAM.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | arbitrate AW vs AR, latch id/len/word index of the winner
// ST_WR_DATA  | accept W beats, write under strobe, leave after beat len
// ST_WR_RESP  | hold B response until bready
// ST_RD_FETCH | first RAM read of the burst is in flight
// ST_RD_DATA  | present R beat; prefetch next word on each non-last handshake
module axi_mem_slave
   import axi_mem_slave_pkg::*;
#(
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ADDR_W = 32,
   parameter int AXI_DATA_W = 32,
   parameter int MEM_ADDR_W = 16,
   parameter int AXI_LEN_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AXI_ID_W-1:0]     axi_awid,
   input  logic [AXI_ADDR_W-1:0]   axi_awaddr,
   input  logic [AXI_LEN_W-1:0]    axi_awlen,
   input  logic [2:0]              axi_awsize,
   input  logic [1:0]              axi_awburst,
   input  logic                    axi_awvalid,
   output logic                    axi_awready,
   input  logic [AXI_DATA_W-1:0]   axi_wdata,
   input  logic [AXI_DATA_W/8-1:0] axi_wstrb,
   input  logic                    axi_wlast,
   input  logic                    axi_wvalid,
   output logic                    axi_wready,
   output logic [AXI_ID_W-1:0]     axi_bid,
   output logic [1:0]              axi_bresp,
   output logic                    axi_bvalid,
   input  logic                    axi_bready,
   input  logic [AXI_ID_W-1:0]     axi_arid,
   input  logic [AXI_ADDR_W-1:0]   axi_araddr,
   input  logic [AXI_LEN_W-1:0]    axi_arlen,
   input  logic [2:0]              axi_arsize,
   input  logic [1:0]              axi_arburst,
   input  logic                    axi_arvalid,
   output logic                    axi_arready,
   output logic [AXI_ID_W-1:0]     axi_rid,
   output logic [AXI_DATA_W-1:0]   axi_rdata,
   output logic [1:0]              axi_rresp,
   output logic                    axi_rlast,
   output logic                    axi_rvalid,
   input  logic                    axi_rready
);

   localparam int LANES  = byte_lanes(AXI_DATA_W);
   localparam int LANE_B = $clog2(LANES);
   localparam int CNT_W  = AXI_LEN_W + 1;

   state_t                r_state;
   state_t                w_next;
   logic                  r_wr_first;
   logic [AXI_ID_W-1:0]   r_awid;
   logic [AXI_ID_W-1:0]   r_arid;
   logic [AXI_LEN_W-1:0]  r_len;
   logic [CNT_W-1:0]      r_cnt;
   logic [MEM_ADDR_W-1:0] r_idx;

   logic                  w_grant_wr;
   logic                  w_grant_rd;
   logic                  w_w_hs;
   logic                  w_r_hs;
   logic                  w_last;
   logic [MEM_ADDR_W-1:0] w_idx_inc;
   logic                  w_ram_en;
   logic [LANES-1:0]      w_ram_we;
   logic [MEM_ADDR_W-1:0] w_ram_addr;
   logic [AXI_DATA_W-1:0] w_ram_rdata;
   logic                  w_unused;

   // Size, burst type and wlast do not affect behaviour; addresses are
   // only partially decoded.
   assign w_unused = ^{axi_awsize, axi_awburst, axi_arsize, axi_arburst,
                       axi_wlast, axi_awaddr, axi_araddr};

   // When both channels request, the one not served last wins.
   assign w_grant_wr = (r_state == ST_IDLE) && axi_awvalid && (!axi_arvalid || r_wr_first);
   assign w_grant_rd = (r_state == ST_IDLE) && axi_arvalid && (!axi_awvalid || !r_wr_first);
   assign w_w_hs     = (r_state == ST_WR_DATA) && axi_wvalid;
   assign w_r_hs     = (r_state == ST_RD_DATA) && axi_rready;
   assign w_last     = (r_cnt == {1'b0, r_len});
   assign w_idx_inc  = r_idx + MEM_ADDR_W'(1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and RAM port control.
   always_comb begin
      w_next     = r_state;
      w_ram_en   = 1'b0;
      w_ram_we   = '0;
      w_ram_addr = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_wr) begin
               w_next = ST_WR_DATA;
            end else if (w_grant_rd) begin
               w_next = ST_RD_FETCH;
            end
         end
         ST_WR_DATA: begin
            if (w_w_hs) begin
               w_ram_en = 1'b1;
               w_ram_we = axi_wstrb;
               if (w_last) begin
                  w_next = ST_WR_RESP;
               end
            end
         end
         ST_WR_RESP: begin
            if (axi_bready) begin
               w_next = ST_IDLE;
            end
         end
         ST_RD_FETCH: begin
            w_ram_en = 1'b1;
            w_next   = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (w_r_hs) begin
               if (w_last) begin
                  w_next = ST_IDLE;
               end else begin
                  // Fetch the following word now so the next beat has no bubble.
                  w_ram_en   = 1'b1;
                  w_ram_addr = w_idx_inc;
               end
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Burst context: latch on grant, advance index and count per beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_first <= 1'b1;
         r_awid     <= '0;
         r_arid     <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
      end else if (w_grant_wr) begin
         r_wr_first <= 1'b0;
         r_awid     <= axi_awid;
         r_len      <= axi_awlen;
         r_cnt      <= '0;
         r_idx      <= axi_awaddr[MEM_ADDR_W+LANE_B-1:LANE_B];
      end else if (w_grant_rd) begin
         r_wr_first <= 1'b1;
         r_arid     <= axi_arid;
         r_len      <= axi_arlen;
         r_cnt      <= '0;
         r_idx      <= axi_araddr[MEM_ADDR_W+LANE_B-1:LANE_B];
      end else if (w_w_hs || (w_r_hs && !w_last)) begin
         r_cnt      <= r_cnt + CNT_W'(1);
         r_idx      <= w_idx_inc;
      end
   end

   axi_mem_slave_ram #(
      .DATA_W (AXI_DATA_W),
      .ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (axi_wdata),
      .o_rdata (w_ram_rdata)
   );

   assign axi_awready = w_grant_wr;
   assign axi_arready = w_grant_rd;
   assign axi_wready  = (r_state == ST_WR_DATA);
   assign axi_bvalid  = (r_state == ST_WR_RESP);
   assign axi_bid     = r_awid;
   assign axi_bresp   = AXI_RESP_OKAY;
   assign axi_rvalid  = (r_state == ST_RD_DATA);
   assign axi_rid     = r_arid;
   assign axi_rresp   = AXI_RESP_OKAY;
   assign axi_rlast   = (r_state == ST_RD_DATA) && w_last;
   // RAM output register is not reset; mask it outside of a data beat.
   assign axi_rdata   = (r_state == ST_RD_DATA) ? w_ram_rdata : '0;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave with a 16-word RAM so wrap and aliasing are reachable.
module tb_axi_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        axi_awid;
   logic [31:0] axi_awaddr;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wlast;
   logic        axi_wvalid;
   logic        axi_wready;
   logic        axi_bid;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;
   logic        axi_arid;
   logic [31:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic        axi_arvalid;
   logic        axi_arready;
   logic        axi_rid;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast;
   logic        axi_rvalid;
   logic        axi_rready;

   axi_mem_slave #(
      .AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(32), .MEM_ADDR_W(4), .AXI_LEN_W(8)
   ) dut (
      .clk(clk), .rst(rst),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
      .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   int checks = 0;
   int passes = 0;

   // Reference memory: word k holds whatever was last written to byte address
   // 4*k modulo 64, lane by lane.
   logic [31:0] ref_mem [16];

   logic [31:0] wq[$];
   logic [3:0]  sq[$];
   int          c_aw, c_ar, c_b, b_hold_err;
   logic        b_id;
   logic [1:0]  b_resp;
   logic [31:0] rd_data[$];
   bit          rd_last[$];
   logic        rd_id;
   int          rd_lat, rd_stall_err, rd_bubbles;

   function automatic int unsigned widx(input logic [31:0] a);
      return (a >> 2) % 16;
   endfunction

   task automatic model_write(input logic [31:0] addr, input int len);
      for (int i = 0; i <= len; i++) begin
         int unsigned k;
         k = (widx(addr) + i) % 16;
         for (int b = 0; b < 4; b++)
            if (sq[i][b]) ref_mem[k][b*8 +: 8] = wq[i][b*8 +: 8];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic to_fail(input string what);
      checks++;
      $display("FAIL timeout_%s: handshake not seen within cycle budget, required within budget", what);
   endtask

   task automatic clear_inputs();
      axi_awvalid = 0; axi_awid = 0; axi_awaddr = 0; axi_awlen = 0;
      axi_awsize = 3'd2; axi_awburst = 2'b01;
      axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_bready = 0;
      axi_arvalid = 0; axi_arid = 0; axi_araddr = 0; axi_arlen = 0;
      axi_arsize = 3'd2; axi_arburst = 2'b01; axi_rready = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      clear_inputs();
      tick(); tick();
      rst = 0;
      tick();
   endtask

   task automatic aw_phase(input logic id, input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      axi_awvalid = 1; axi_awid = id; axi_awaddr = addr; axi_awlen = len;
      forever begin
         #1;
         if (axi_awready) begin c_aw = cyc_cnt; tick(); break; end
         tick(); n++;
         if (n > 100) begin to_fail("aw"); break; end
      end
      axi_awvalid = 0;
   endtask

   task automatic ar_phase(input logic id, input logic [31:0] addr, input logic [7:0] len);
      int n = 0;
      axi_arvalid = 1; axi_arid = id; axi_araddr = addr; axi_arlen = len;
      forever begin
         #1;
         if (axi_arready) begin c_ar = cyc_cnt; tick(); break; end
         tick(); n++;
         if (n > 100) begin to_fail("ar"); break; end
      end
      axi_arvalid = 0;
   endtask

   task automatic w_phase(input int len);
      for (int i = 0; i <= len; i++) begin
         int n = 0;
         axi_wvalid = 1; axi_wdata = wq[i]; axi_wstrb = sq[i]; axi_wlast = (i == len);
         forever begin
            #1;
            if (axi_wready) begin tick(); break; end
            tick(); n++;
            if (n > 100) begin to_fail("w"); break; end
         end
      end
      axi_wvalid = 0; axi_wlast = 0;
   endtask

   task automatic b_phase(input int hold);
      int n = 0;
      b_hold_err = 0;
      axi_bready = (hold == 0);
      forever begin
         #1;
         if (axi_bvalid) break;
         tick(); n++;
         if (n > 100) begin to_fail("b"); axi_bready = 0; return; end
      end
      c_b = cyc_cnt; b_id = axi_bid; b_resp = axi_bresp;
      for (int i = 0; i < hold; i++) begin
         tick(); #1;
         if (!axi_bvalid || axi_bid !== b_id || axi_bresp !== b_resp) b_hold_err++;
      end
      axi_bready = 1;
      tick();
      axi_bready = 0;
   endtask

   // mode 0: rready always high, 1: toggles each cycle, 2: random
   task automatic r_phase(input int mode);
      int n = 0;
      bit started = 0, done = 0, prev_stall = 0, rr = 0;
      logic [31:0] pd;
      logic pl;
      rd_data.delete(); rd_last.delete();
      rd_stall_err = 0; rd_bubbles = 0; rd_lat = -1;
      while (!done) begin
         case (mode)
            0: rr = 1;
            1: rr = ~rr;
            default: rr = 1'($urandom_range(0, 1));
         endcase
         axi_rready = rr;
         #1;
         if (axi_rvalid) begin
            if (!started) begin started = 1; rd_lat = cyc_cnt - c_ar; end
            if (prev_stall && (axi_rdata !== pd || axi_rlast !== pl)) rd_stall_err++;
            prev_stall = !rr; pd = axi_rdata; pl = axi_rlast; rd_id = axi_rid;
            if (rr) begin
               rd_data.push_back(axi_rdata);
               rd_last.push_back(axi_rlast);
               if (axi_rlast) done = 1;
            end
         end else begin
            prev_stall = 0;
            if (started) rd_bubbles++;
         end
         tick(); n++;
         if (!done && n > 300) begin to_fail("r"); break; end
      end
      axi_rready = 0;
   endtask

   task automatic check_read(input string name, input logic [31:0] addr, input int len);
      checks++;
      if (rd_data.size() != len + 1)
         $display("FAIL %s_beats: got %0d beats, want %0d", name, rd_data.size(), len + 1);
      else passes++;
      for (int i = 0; i < rd_data.size(); i++) begin
         logic [31:0] exp;
         exp = ref_mem[(widx(addr) + i) % 16];
         checks++;
         if (rd_data[i] !== exp || rd_last[i] !== (i == len))
            $display("FAIL %s_beat%0d: got data %h last %0d, want data %h last %0d",
                     name, i, rd_data[i], rd_last[i], exp, (i == len));
         else passes++;
      end
      checks++;
      if (rd_bubbles != 0 || rd_stall_err != 0)
         $display("FAIL %s_flow: got %0d bubbles %0d unstable stalls, want 0 and 0",
                  name, rd_bubbles, rd_stall_err);
      else passes++;
   endtask

   task automatic test_reset();
      logic [43:0] outs;
      rst = 1;
      clear_inputs();
      tick(); tick();
      outs = {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
              axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast};
      checks++;
      if (outs !== 44'd0) $display("FAIL reset_outputs_in_reset: got %h want 0", outs);
      else passes++;
      rst = 0;
      tick(); #1;
      outs = {axi_awready, axi_arready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
              axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast};
      checks++;
      if (outs !== 44'd0) $display("FAIL reset_outputs_idle: got %h want 0", outs);
      else passes++;
      tick();
   endtask

   task automatic test_fill();
      wq.delete(); sq.delete();
      for (int i = 0; i < 16; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
      aw_phase(0, 32'h0, 8'd15); w_phase(15); b_phase(0);
      model_write(32'h0, 15);
      checks++;
      if (b_resp !== 2'b00) $display("FAIL fill_bresp: got %b want 00", b_resp);
      else passes++;
      ar_phase(0, 32'h0, 8'd15); r_phase(2);
      check_read("fill", 32'h0, 15);
   endtask

   task automatic test_single();
      wq = '{32'hDEADBEEF}; sq = '{4'hF};
      aw_phase(1, 32'h10, 8'd0); w_phase(0); b_phase(2);
      model_write(32'h10, 0);
      checks++;
      if (c_b - c_aw != 2 || b_resp !== 2'b00 || b_id !== 1'b1 || b_hold_err != 0)
         $display("FAIL single_b: got lat %0d resp %b id %0d holderr %0d, want lat 2 resp 00 id 1 holderr 0",
                  c_b - c_aw, b_resp, b_id, b_hold_err);
      else passes++;
      ar_phase(0, 32'h10, 8'd0); r_phase(0);
      checks++;
      if (rd_lat != 2 || rd_data.size() != 1 || rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_id !== 1'b0)
         $display("FAIL single_r: got lat %0d n %0d data %h last %0d id %0d, want lat 2 n 1 data deadbeef last 1 id 0",
                  rd_lat, rd_data.size(), rd_data[0], rd_last[0], rd_id);
      else passes++;
   endtask

   task automatic test_strobe();
      wq = '{32'hAABBCCDD}; sq = '{4'hF};
      aw_phase(0, 32'h20, 8'd0); w_phase(0); b_phase(0); model_write(32'h20, 0);
      wq = '{32'h11223344}; sq = '{4'h5};
      aw_phase(0, 32'h20, 8'd0); w_phase(0); b_phase(0); model_write(32'h20, 0);
      ar_phase(1, 32'h20, 8'd0); r_phase(0);
      checks++;
      if (rd_data[0] !== 32'hAA22CC44 || rd_id !== 1'b1)
         $display("FAIL strobe_merge: got %h id %0d want aa22cc44 id 1", rd_data[0], rd_id);
      else passes++;
   endtask

   task automatic test_burst();
      wq.delete(); sq.delete();
      for (int i = 0; i < 8; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
      aw_phase(0, 32'h100, 8'd7); w_phase(7); b_phase(0); model_write(32'h100, 7);
      ar_phase(0, 32'h100, 8'd7); r_phase(0);
      checks++;
      if (rd_lat != 2) $display("FAIL burst_latency: got %0d want 2", rd_lat);
      else passes++;
      check_read("burst_full", 32'h100, 7);
      ar_phase(0, 32'h100, 8'd7); r_phase(1);
      check_read("burst_toggle", 32'h100, 7);
   endtask

   task automatic test_arbitration();
      do_reset();
      axi_awvalid = 1; axi_awid = 1; axi_awaddr = 32'h30; axi_awlen = 0;
      axi_arvalid = 1; axi_arid = 0; axi_araddr = 32'h10; axi_arlen = 0;
      #1;
      checks++;
      if ({axi_awready, axi_arready} !== 2'b10)
         $display("FAIL arb_first: got aw/ar ready %b want 10", {axi_awready, axi_arready});
      else passes++;
      c_aw = cyc_cnt;
      tick();
      axi_awvalid = 0;
      wq = '{$urandom}; sq = '{4'hF};
      w_phase(0);
      axi_awvalid = 1; axi_awid = 1; axi_awaddr = 32'h34; axi_awlen = 0;
      b_phase(0);
      model_write(32'h30, 0);
      checks++;
      if (b_id !== 1'b1) $display("FAIL arb_bid: got %0d want 1", b_id);
      else passes++;
      #1;
      checks++;
      if ({axi_awready, axi_arready} !== 2'b01)
         $display("FAIL arb_second: got aw/ar ready %b want 01", {axi_awready, axi_arready});
      else passes++;
      c_ar = cyc_cnt;
      tick();
      axi_arvalid = 0;
      r_phase(0);
      checks++;
      if (rd_id !== 1'b0 || rd_data[0] !== ref_mem[4])
         $display("FAIL arb_rid: got id %0d data %h want id 0 data %h", rd_id, rd_data[0], ref_mem[4]);
      else passes++;
      wq = '{$urandom}; sq = '{4'hF};
      aw_phase(1, 32'h34, 8'd0); w_phase(0); b_phase(0); model_write(32'h34, 0);
      ar_phase(0, 32'h30, 8'd1); r_phase(2);
      check_read("arb_readback", 32'h30, 1);
   endtask

   task automatic test_wrap();
      logic [31:0] beat3;
      wq.delete(); sq.delete();
      for (int i = 0; i < 4; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
      beat3 = wq[2];
      aw_phase(0, 32'h38, 8'd3); w_phase(3); b_phase(0); model_write(32'h38, 3);
      ar_phase(0, 32'h0, 8'd0); r_phase(0);
      checks++;
      if (rd_data[0] !== beat3) $display("FAIL wrap_word0: got %h want %h", rd_data[0], beat3);
      else passes++;
      ar_phase(1, 32'h38, 8'd3); r_phase(2);
      check_read("wrap_burst", 32'h38, 3);
   endtask

   task automatic test_reset_mid();
      int n = 0, beats = 0;
      ar_phase(1, 32'h38, 8'd3);
      axi_rready = 1;
      while (beats < 1 && n < 20) begin
         #1;
         if (axi_rvalid) beats++;
         tick(); n++;
      end
      if (n >= 20) to_fail("midrd");
      #1;
      checks++;
      if (axi_rvalid !== 1'b1 || axi_rdata !== ref_mem[15])
         $display("FAIL midrd_beat2: got valid %0d data %h want valid 1 data %h", axi_rvalid, axi_rdata, ref_mem[15]);
      else passes++;
      rst = 1;
      tick();
      checks++;
      if (axi_rvalid !== 1'b0 || axi_rdata !== 32'h0)
         $display("FAIL midrd_drop: got rvalid %0d rdata %h want 0 0", axi_rvalid, axi_rdata);
      else passes++;
      rst = 0; axi_rready = 0;
      axi_arvalid = 1; axi_arid = 0; axi_araddr = 32'h3C; axi_arlen = 0;
      #1;
      checks++;
      if (axi_arready !== 1'b1) $display("FAIL midrd_restart: got arready %0d want 1", axi_arready);
      else passes++;
      c_ar = cyc_cnt;
      tick();
      axi_arvalid = 0;
      r_phase(0);
      check_read("midrd_after", 32'h3C, 0);
      // abort a 4-beat write after two beats
      wq.delete(); sq.delete();
      for (int i = 0; i < 2; i++) begin wq.push_back($urandom); sq.push_back(4'hF); end
      aw_phase(0, 32'h20, 8'd3); w_phase(1);
      rst = 1; tick(); rst = 0; tick();
      model_write(32'h20, 1);
      ar_phase(0, 32'h20, 8'd3); r_phase(0);
      check_read("midwr_persist", 32'h20, 3);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         logic        id;
         logic [31:0] addr;
         int          len;
         id   = 1'($urandom_range(0, 1));
         addr = $urandom;
         len  = $urandom_range(0, 5);
         if ($urandom_range(0, 1) == 1) begin
            wq.delete(); sq.delete();
            for (int i = 0; i <= len; i++) begin
               wq.push_back($urandom); sq.push_back(4'($urandom_range(0, 15)));
            end
            aw_phase(id, addr, 8'(len)); w_phase(len); b_phase($urandom_range(0, 2));
            model_write(addr, len);
            checks++;
            if (b_id !== id || b_resp !== 2'b00 || b_hold_err != 0)
               $display("FAIL rand_b%0d: got id %0d resp %b holderr %0d want id %0d resp 00 holderr 0",
                        t, b_id, b_resp, b_hold_err, id);
            else passes++;
         end else begin
            ar_phase(id, addr, 8'(len)); r_phase(2);
            checks++;
            if (rd_id !== id || rd_lat != 2)
               $display("FAIL rand_r%0d: got id %0d lat %0d want id %0d lat 2", t, rd_id, rd_lat, id);
            else passes++;
            check_read("rand_rd", addr, len);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_single();
      test_strobe();
      test_burst();
      test_arbitration();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule
